// File: rtl/flash_writer_if.sv
// flash_writer_if: command handshake, status and single-bit SPI pins
// shared by the flash write engine and whoever drives it.
interface flash_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [21:0] cmd_adr;
  logic [15:0] cmd_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        mspi_cs;
  logic        mspi_di;
  logic        mspi_do;

  modport master (
    output cmd_valid, cmd_op, cmd_adr, cmd_data, mspi_do,
    input  cmd_ready, busy, done, error, mspi_cs, mspi_di
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_adr, cmd_data, mspi_do,
    output cmd_ready, busy, done, error, mspi_cs, mspi_di
  );
endinterface

// File: rtl/flash_writer.sv
// flash_writer: W25Q64 single-bit SPI sector erase / word program.
// Sequence per command: WREN, erase or program, then poll WIP.
module flash_writer #(
  parameter int          CS_GAP     = 4,
  parameter logic [31:0] POLL_LIMIT = 32'd4_000_000
) (
  input logic           flash_clk,
  input logic           flash_reset,
  flash_writer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN,
    S_GAP1,
    S_CMD,
    S_GAP2,
    S_POLL,
    S_GAP3,
    S_DONE
  } state_t;

  localparam logic [47:0] WREN_W  = {8'h06, 40'h0};
  localparam logic [47:0] POLL_W  = {8'h05, 8'hFF, 32'h0};
  localparam logic [15:0] GAP_INI = 16'(CS_GAP - 1);

  state_t      r_state;
  logic [47:0] r_shift;
  logic [5:0]  r_bits;
  logic [15:0] r_gap;
  logic [31:0] r_poll_cnt;
  logic        r_op;
  logic [21:0] r_adr;
  logic [15:0] r_data;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_cs;
  logic        r_di;

  logic [23:0] w_badr;
  logic [23:0] w_eadr;
  logic [47:0] w_cmd;
  logic [5:0]  w_cmd_last;
  logic [31:0] w_cnt_next;
  logic        w_accept;
  logic        w_xfer_st;
  logic        w_gap_st;

  assign w_badr     = {1'b0, r_adr, 1'b0};
  assign w_eadr     = {w_badr[23:12], 12'h000};
  assign w_cmd      = r_op ? {8'h02, w_badr, r_data}
                           : {8'h20, w_eadr, 16'h0000};
  assign w_cmd_last = r_op ? 6'd47 : 6'd31;
  assign w_cnt_next = r_poll_cnt + 32'd1;
  assign w_accept   = bus.cmd_valid && bus.cmd_ready;
  assign w_xfer_st  = (r_state == S_WREN) || (r_state == S_CMD)
                   || (r_state == S_POLL);
  assign w_gap_st   = (r_state == S_GAP1) || (r_state == S_GAP2)
                   || (r_state == S_GAP3);

  assign bus.cmd_ready = (r_state == S_IDLE) && !flash_reset;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
  assign bus.mspi_cs   = r_cs;
  assign bus.mspi_di   = r_di;

  always_ff @(posedge flash_clk) begin
    if (flash_reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bits     <= '0;
      r_gap      <= '0;
      r_poll_cnt <= '0;
      r_op       <= 1'b0;
      r_adr      <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cs       <= 1'b1;
      r_di       <= 1'b1;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_op       <= bus.cmd_op;
        r_adr      <= bus.cmd_adr;
        r_data     <= bus.cmd_data;
        r_poll_cnt <= '0;
        r_error    <= 1'b0;
        r_busy     <= 1'b1;
        r_cs       <= 1'b0;
        r_di       <= WREN_W[47];
        r_shift    <= WREN_W << 1;
        r_bits     <= 6'd7;
        r_state    <= S_WREN;
      end
    end else if (w_xfer_st) begin
      if (r_bits != 6'd0) begin
        r_di    <= r_shift[47];
        r_shift <= r_shift << 1;
        r_bits  <= r_bits - 6'd1;
      end else begin
        r_cs  <= 1'b1;
        r_di  <= 1'b1;
        r_gap <= GAP_INI;
        if (r_state == S_WREN) begin
          r_state <= S_GAP1;
        end else if (r_state == S_CMD) begin
          r_state <= S_GAP2;
        end else begin
          // the last status bit is WIP, sampled live on this edge
          r_poll_cnt <= w_cnt_next;
          if (!bus.mspi_do) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_cnt_next >= POLL_LIMIT) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_GAP3;
          end
        end
      end
    end else if (w_gap_st) begin
      if (r_gap != 16'd0) begin
        r_gap <= r_gap - 16'd1;
      end else if (r_state == S_GAP1) begin
        r_cs    <= 1'b0;
        r_di    <= w_cmd[47];
        r_shift <= w_cmd << 1;
        r_bits  <= w_cmd_last;
        r_state <= S_CMD;
      end else begin
        r_cs    <= 1'b0;
        r_di    <= POLL_W[47];
        r_shift <= POLL_W << 1;
        r_bits  <= 6'd15;
        r_state <= S_POLL;
      end
    end else begin
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_state <= S_IDLE;
    end
  end

endmodule

// File: doc/flash_writer.md
Name: flash_writer

Overview:
- Programs and erases the W25Q64 SPI flash in single-bit SPI mode. It is the write-side counterpart to the existing DSPI flash read path.
- Accepts one command at a time: 4 KB sector erase or 16-bit word program. For each command it issues WRITE ENABLE, then the erase/program command, then polls the status register until WIP clears.
- Sits beside the read block in the flash_clk domain. The top level muxes mspi_cs/mspi_di onto the pins while this block is busy, and holds IO1 undriven during that time.
- The SPI clock pin is the existing continuous phase-shifted PLL output; this block only gates it through CS.

Parameters:
- CS_GAP, 4: flash_clk cycles mspi_cs stays high between consecutive transfers. Minimum 1.
- POLL_LIMIT, 32'd4_000_000: maximum status-read transfers per command before abort with error.

Ports:
- flash_clk  in  1  block clock; also the SPI bit clock (one bit per cycle).
- flash_reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when idle; a command is accepted on a cycle with cmd_valid && cmd_ready.
- cmd_op  in  1  0 = sector erase, 1 = word program.
- cmd_adr  in  22  word address, same addressing as the read path. Byte address = {1'b0, cmd_adr, 1'b0}.
- cmd_data  in  16  program data; [15:8] goes to the even byte, [7:0] to the odd byte.
- busy  out  1  high from the acceptance cycle+1 until the done cycle, inclusive.
- done  out  1  one-cycle pulse at completion.
- error  out  1  status of the last command; 1 = poll timeout. Valid at done and held until the next acceptance.
- mspi_cs  out  1  flash chip select, active low.
- mspi_di  out  1  flash IO0 (MOSI).
- mspi_do  in  1  flash IO1 (MISO).

Behaviour:
- Reset values: cmd_ready=0 during reset and 1 after. busy=0, done=0, error=0, mspi_cs=1, mspi_di=1. State = IDLE, all counters 0.
  - Reset mid-operation aborts immediately: CS high on the cycle after reset is asserted, no done pulse.
- Command capture: on acceptance, cmd_op, cmd_adr and cmd_data are latched. Inputs are ignored while busy, and cmd_valid while busy has no effect.
  - Erase address: byte address with bits [11:0] forced to 0.
- States: IDLE -> WREN -> GAP1 -> CMD -> GAP2 -> POLL -> GAP3 -> DONE -> IDLE.
  - From POLL, a busy status goes to GAP3 then back to POLL.
- Common transfer rules:
  - mspi_cs goes low on the first bit cycle.
  - One bit per flash_clk cycle on mspi_di, MSB first.
  - mspi_cs goes high on the cycle after the last bit.
  - Each GAP state holds mspi_cs=1 and mspi_di=1 for exactly CS_GAP cycles.
- WREN: 8 bits, 0x06. The first bit is driven on the cycle after acceptance.
- CMD:
  - Erase: 0x20 + 24-bit address, 32 bits total.
  - Program: 0x02 + 24-bit address + cmd_data[15:0], 48 bits total.
- POLL:
  - 16-bit transfer: 0x05 on mspi_di, then 8 bits with mspi_di=1.
  - mspi_do is sampled at the flash_clk edge ending bit cycles 9..16, MSB first.
  - Status bit0 (WIP) = sample from cycle 16.
  - WIP=0: go to DONE.
  - WIP=1 and poll count < POLL_LIMIT: go to GAP3, then POLL again.
  - WIP=1 and poll count = POLL_LIMIT: error=1, go to DONE.
- DONE: exactly one cycle. done=1, busy=1, mspi_cs=1. The next cycle is IDLE with cmd_ready=1.
- Poll counter: 32-bit, cleared on acceptance, incremented at the end of each POLL transfer. It never wraps because the limit is checked first.
- Minimum latency: from acceptance to done is 8 + CS_GAP + (32 or 48) + CS_GAP + 16 + 1 cycles, assuming WIP=0 on the first poll.
  - Program with CS_GAP=4: 81 cycles.
- No back-to-back command overlap: a cmd_valid held through DONE is accepted on the first IDLE cycle.

Test Plan:
- Program: cmd_adr=22'h000123, data=16'hA55A, model status 0x03, 0x03, 0x00.
  - Required bytes: 06 | gap | 02 00 02 46 A5 5A | gap | three 0x05 polls.
  - done after the 3rd poll, error=0, busy high throughout.
- Erase: cmd_adr=22'h000FFF.
  - Required CMD bytes: 20 00 10 00 (32 bits), then poll.
  - Status 0x00 on the first poll gives done at 8+4+32+4+16+1 = 65 cycles after acceptance.
- Timeout: POLL_LIMIT=3, model status stuck at 0x01.
  - Exactly 3 poll transfers, then done with error=1.
  - The next successful command clears error to 0.
- CS_GAP: with CS_GAP=1, mspi_cs is high exactly 1 cycle between WREN/CMD and between polls. Check every gap length.
- Busy handshake: pulse cmd_valid with a different address during POLL.
  - The command is ignored and the transferred address is unchanged.
  - cmd_ready=0 until the cycle after done.
- Reset mid-CMD: assert flash_reset at bit 20 of a program.
  - Next cycle: mspi_cs=1, busy=0, done=0.
  - After release, cmd_ready=1 and a new erase runs correctly.
